// File: rtl/bg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bg_pkg
// Description : Shared types and defaults for the background tile renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package bg_pkg;

  typedef logic [7:0] rgb332_t;

  localparam rgb332_t PAL_DEF0 = 8'h00;
  localparam rgb332_t PAL_DEF1 = 8'h1C;
  localparam rgb332_t PAL_DEF2 = 8'hE0;
  localparam rgb332_t PAL_DEF3 = 8'hFF;

  localparam int TILE_W_DEF   = 10;
  localparam int TILE_H_DEF   = 15;
  localparam int COL_BITS_DEF = 6;
  localparam int SYNC_DELAY   = 2;

  function automatic rgb332_t pal_default(input logic [1:0] code);
    case (code)
      2'd0:    return PAL_DEF0;
      2'd1:    return PAL_DEF1;
      2'd2:    return PAL_DEF2;
      default: return PAL_DEF3;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bg_tile_counter.sv
`default_nettype none
// ============================================================================
// Module      : bg_tile_counter
// Description : Raster position counters (pixel/tile column, line/tile row)
//               with line-end and frame-start handling.
// Revision    : 1.0 - initial release
// ============================================================================
module bg_tile_counter
  import bg_pkg::*;
#(
  parameter int COL_BITS = COL_BITS_DEF,
  parameter int ROW_BITS = 5,
  parameter int TILE_W   = TILE_W_DEF,
  parameter int TILE_H   = TILE_H_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_pix_en,
  input  logic                i_de,
  input  logic                i_vs_n,
  output logic [COL_BITS-1:0] o_tcol,
  output logic [ROW_BITS-1:0] o_trow
);

  localparam int PX_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int PY_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(TILE_W - 1);
  localparam logic [PY_W-1:0] PY_LAST = PY_W'(TILE_H - 1);

  logic [PX_W-1:0]     r_px;
  logic [PY_W-1:0]     r_py;
  logic [COL_BITS-1:0] r_tcol;
  logic [ROW_BITS-1:0] r_trow;
  logic                r_de_prev;
  logic                w_line_end;

  assign w_line_end = !i_de && r_de_prev;
  assign o_tcol     = r_tcol;
  assign o_trow     = r_trow;

  // Frame start outranks line end; tcol/trow wrap naturally at their widths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_px      <= '0;
      r_py      <= '0;
      r_tcol    <= '0;
      r_trow    <= '0;
      r_de_prev <= 1'b0;
    end else if (i_pix_en) begin
      r_de_prev <= i_de;
      if (!i_vs_n) begin
        r_px   <= '0;
        r_py   <= '0;
        r_tcol <= '0;
        r_trow <= '0;
      end else if (w_line_end) begin
        r_px   <= '0;
        r_tcol <= '0;
        if (r_py == PY_LAST) begin
          r_py   <= '0;
          r_trow <= r_trow + 1'b1;
        end else begin
          r_py <= r_py + 1'b1;
        end
      end else if (i_de) begin
        if (r_px == PX_LAST) begin
          r_px   <= '0;
          r_tcol <= r_tcol + 1'b1;
        end else begin
          r_px <= r_px + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bg_tile_renderer.sv
`default_nettype none
// ============================================================================
// Module      : bg_tile_renderer
// Description : Background tile renderer: tile-map addressing, 4-entry
//               palette lookup to RGB332 and 2-strobe sync alignment.
//               Define BG_PALETTE_WR_EN for a run-time writable palette.
// Revision    : 1.0 - initial release
// ============================================================================
module bg_tile_renderer
  import bg_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 2,
  parameter int COL_BITS   = COL_BITS_DEF,
  parameter int TILE_W     = TILE_W_DEF,
  parameter int TILE_H     = TILE_H_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_en,
  input  logic                  de_in,
  input  logic                  hs_in,
  input  logic                  vs_in,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [7:0]            rgb,
  output logic                  hs_out,
  output logic                  vs_out,
  output logic                  de_out
`ifdef BG_PALETTE_WR_EN
  ,
  input  logic                  pal_we,
  input  logic [1:0]            pal_idx,
  input  logic [7:0]            pal_data
`endif
);

  localparam int ROW_BITS = ADDR_WIDTH - COL_BITS;

  logic [COL_BITS-1:0] w_tcol;
  logic [ROW_BITS-1:0] w_trow;
  logic [1:0]          w_code;
  rgb332_t             w_pal_rgb;
  logic                r_de_d1;
  logic                r_hs_d1;
  logic                r_vs_d1;

  bg_tile_counter #(
    .COL_BITS (COL_BITS),
    .ROW_BITS (ROW_BITS),
    .TILE_W   (TILE_W),
    .TILE_H   (TILE_H)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_pix_en (pix_en),
    .i_de     (de_in),
    .i_vs_n   (vs_in),
    .o_tcol   (w_tcol),
    .o_trow   (w_trow)
  );

  assign w_code = rdata[1:0];

`ifdef BG_PALETTE_WR_EN
  rgb332_t r_pal [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pal[0] <= PAL_DEF0;
      r_pal[1] <= PAL_DEF1;
      r_pal[2] <= PAL_DEF2;
      r_pal[3] <= PAL_DEF3;
    end else if (pal_we) begin
      r_pal[pal_idx] <= pal_data;
    end
  end

  assign w_pal_rgb = r_pal[w_code];
`else
  assign w_pal_rgb = pal_default(w_code);
`endif

  // Stage 1 presents the address and holds it between strobes; stage 2
  // consumes the returned code alongside the matching delayed enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr    <= '0;
      r_de_d1 <= 1'b0;
      r_hs_d1 <= 1'b1;
      r_vs_d1 <= 1'b1;
      rgb     <= '0;
      de_out  <= 1'b0;
      hs_out  <= 1'b1;
      vs_out  <= 1'b1;
    end else if (pix_en) begin
      addr    <= {w_trow, w_tcol};
      r_de_d1 <= de_in;
      r_hs_d1 <= hs_in;
      r_vs_d1 <= vs_in;
      rgb     <= r_de_d1 ? w_pal_rgb : 8'h00;
      de_out  <= r_de_d1;
      hs_out  <= r_hs_d1;
      vs_out  <= r_vs_d1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bg_tile_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bg_tile_renderer
// Description : Scoreboard bench for bg_tile_renderer with a mod-4 map RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bg_tile_renderer;

  localparam int TW = 10;
  localparam int TH = 15;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        pix_en = 1'b0;
  logic        de_in  = 1'b0;
  logic        hs_in  = 1'b1;
  logic        vs_in  = 1'b1;
  logic [10:0] addr;
  logic [1:0]  rdata;
  logic [7:0]  rgb;
  logic        hs_out;
  logic        vs_out;
  logic        de_out;
  logic        force3 = 1'b0;
`ifdef BG_PALETTE_WR_EN
  logic        pal_we   = 1'b0;
  logic [1:0]  pal_idx  = 2'd0;
  logic [7:0]  pal_data = 8'h00;
`endif

  always #5 clk = ~clk;

  // Map RAM: code = addr mod 4, data presented one clk after the address.
  assign rdata = force3 ? 2'd3 : addr[1:0];

  bg_tile_renderer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .de_in  (de_in),
    .hs_in  (hs_in),
    .vs_in  (vs_in),
    .addr   (addr),
    .rdata  (rdata),
    .rgb    (rgb),
    .hs_out (hs_out),
    .vs_out (vs_out),
    .de_out (de_out)
`ifdef BG_PALETTE_WR_EN
    ,
    .pal_we   (pal_we),
    .pal_idx  (pal_idx),
    .pal_data (pal_data)
`endif
  );

  typedef struct packed {
    logic [1:0] code;
    logic       de;
    logic       hs;
    logic       vs;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  int          gap    = 0;
  exp_t        sb [$];
  logic [7:0]  exp_pal [4];
  int          m_line = 0;
  int          m_pix  = 0;
  logic        m_prev_de = 1'b0;
  logic [10:0] first_addr;

  function automatic logic [10:0] model_addr();
    logic [4:0] r;
    logic [5:0] c;
    r = 5'((m_line / TH) % 32);
    c = 6'((m_pix / TW) % 64);
    return {r, c};
  endfunction

  task automatic drive_strobe(input logic de, input logic hs, input logic vs, input string tag);
    logic [10:0] ea;
    exp_t        e;
    logic [10:0] want;
    logic [10:0] got;
    ea     = model_addr();
    e.code = ea[1:0];
    e.de   = de;
    e.hs   = hs;
    e.vs   = vs;
    sb.push_back(e);
    de_in  = de;
    hs_in  = hs;
    vs_in  = vs;
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    checks++;
    if (addr !== ea) begin
      errors++;
      $display("FAIL %s addr: got %0d want %0d", tag, addr, ea);
    end
    if (sb.size() == 2) begin
      e    = sb.pop_front();
      want = {(e.de ? exp_pal[e.code] : 8'h00), e.hs, e.vs, e.de};
      got  = {rgb, hs_out, vs_out, de_out};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s pipe: got rgb=%h hs=%b vs=%b de=%b want rgb=%h hs=%b vs=%b de=%b",
                 tag, got[10:3], got[2], got[1], got[0], want[10:3], want[2], want[1], want[0]);
      end
    end
    if (!vs) begin
      m_line = 0;
      m_pix  = 0;
    end else if (!de && m_prev_de) begin
      m_line++;
      m_pix = 0;
    end else if (de) begin
      m_pix++;
    end
    m_prev_de = de;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame_start();
    drive_strobe(1'b0, 1'b1, 1'b0, "vsync");
    drive_strobe(1'b0, 1'b1, 1'b0, "vsync");
    drive_strobe(1'b0, 1'b1, 1'b1, "vsync");
  endtask

  task automatic run_line(input int nde, input int nblank, input bit f3, input string tag);
    for (int i = 0; i < nde; i++) begin
      force3 = 1'b0;
      drive_strobe(1'b1, 1'b1, 1'b1, tag);
      if (i == 0) first_addr = addr;
    end
    for (int i = 0; i < nblank; i++) begin
      force3 = f3 && (i > 0);
      drive_strobe(1'b0, (i == 0) ? 1'b0 : 1'b1, 1'b1, tag);
    end
    force3 = 1'b0;
  endtask

  task automatic assert_reset();
    pix_en = 1'b0;
    de_in  = 1'b0;
    hs_in  = 1'b1;
    vs_in  = 1'b1;
    force3 = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    m_line    = 0;
    m_pix     = 0;
    m_prev_de = 1'b0;
    exp_pal   = '{8'h00, 8'h1C, 8'hE0, 8'hFF};
  endtask

  task automatic test_reset();
    release_reset();
    frame_start();
    for (int i = 0; i < 25; i++) drive_strobe(1'b1, 1'b0, 1'b1, "rst_pre");
    assert_reset();
    checks++;
    if (addr !== 11'd0) begin errors++; $display("FAIL reset addr: got %0d want 0", addr); end
    checks++;
    if (rgb !== 8'h00) begin errors++; $display("FAIL reset rgb: got %h want 00", rgb); end
    checks++;
    if (de_out !== 1'b0) begin errors++; $display("FAIL reset de_out: got %b want 0", de_out); end
    checks++;
    if (hs_out !== 1'b1) begin errors++; $display("FAIL reset hs_out: got %b want 1", hs_out); end
    checks++;
    if (vs_out !== 1'b1) begin errors++; $display("FAIL reset vs_out: got %b want 1", vs_out); end
    release_reset();
  endtask

  task automatic test_first_line();
    gap = 0;
    frame_start();
    run_line(640, 2, 1'b0, "line0");
    run_line(10, 2, 1'b0, "line1");
    checks++;
    if (first_addr !== 11'd0) begin
      errors++;
      $display("FAIL line1_start addr: got %0d want 0", first_addr);
    end
  endtask

  task automatic test_row_wrap();
    gap = 0;
    frame_start();
    for (int l = 0; l < 481; l++) begin
      run_line(25, 2, 1'b0, "wrap");
      if (l == 1) begin
        checks++;
        if (first_addr !== 11'd0) begin errors++; $display("FAIL wrap_line1 addr: got %0d want 0", first_addr); end
      end
      if (l == 15) begin
        checks++;
        if (first_addr !== 11'd64) begin errors++; $display("FAIL wrap_line15 addr: got %0d want 64", first_addr); end
      end
      if (l == 480) begin
        checks++;
        if (first_addr !== 11'd0) begin errors++; $display("FAIL wrap_line480 addr: got %0d want 0", first_addr); end
      end
    end
    frame_start();
    run_line(5, 1, 1'b0, "frame2");
    checks++;
    if (first_addr !== 11'd0) begin errors++; $display("FAIL frame2_start addr: got %0d want 0", first_addr); end
  endtask

  task automatic test_sparse_strobe();
    gap = 3;
    frame_start();
    run_line(640, 2, 1'b0, "sparse");
    gap = 0;
  endtask

  task automatic test_blanking();
    gap = 0;
    frame_start();
    for (int l = 0; l < 16; l++) run_line(12, 1, 1'b0, "pre_blank");
    run_line(12, 6, 1'b1, "blank");
    checks++;
    if (rgb !== 8'h00) begin errors++; $display("FAIL blank rgb: got %h want 00", rgb); end
    checks++;
    if (addr !== 11'd64) begin errors++; $display("FAIL blank addr: got %0d want 64", addr); end
    frame_start();
    run_line(5, 1, 1'b0, "midvs");
    checks++;
    if (first_addr !== 11'd0) begin errors++; $display("FAIL midvs addr: got %0d want 0", first_addr); end
  endtask

`ifdef BG_PALETTE_WR_EN
  task automatic test_palette_wr();
    gap = 0;
    @(posedge clk);
    #1;
    pal_we   = 1'b1;
    pal_idx  = 2'd1;
    pal_data = 8'h03;
    @(posedge clk);
    #1;
    pal_we     = 1'b0;
    exp_pal[1] = 8'h03;
    frame_start();
    for (int i = 0; i < 12; i++) drive_strobe(1'b1, 1'b1, 1'b1, "palwr");
    checks++;
    if (rgb !== 8'h03) begin errors++; $display("FAIL palwr rgb: got %h want 03", rgb); end
    drive_strobe(1'b0, 1'b0, 1'b1, "palwr");
    drive_strobe(1'b0, 1'b1, 1'b1, "palwr");
    assert_reset();
    release_reset();
    frame_start();
    for (int i = 0; i < 12; i++) drive_strobe(1'b1, 1'b1, 1'b1, "palrst");
    checks++;
    if (rgb !== 8'h1C) begin errors++; $display("FAIL palrst rgb: got %h want 1c", rgb); end
  endtask
`endif

  initial begin
    exp_pal = '{8'h00, 8'h1C, 8'hE0, 8'hFF};
    test_reset();
    test_first_line();
    test_row_wrap();
    test_sparse_strobe();
    test_blanking();
`ifdef BG_PALETTE_WR_EN
    test_palette_wr();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bg_tile_renderer.md
Name: bg_tile_renderer

Overview:
- Background tile renderer sitting directly upstream of the 2-bit name/tile-code RAM (11-bit address, 1-clock synchronous read).
- Tracks the raster position from the timing generator's pixel strobe, display enable and syncs, and drives the tile-map address.
- Maps the returned 2-bit code through a 4-entry palette to RGB332.
- Delays hsync, vsync and display enable so they stay pixel-aligned with the RGB output.

Parameters:
- ADDR_WIDTH, 11, tile-map address width; split into row bits (ADDR_WIDTH-COL_BITS) and column bits (COL_BITS).
- DATA_WIDTH, 2, tile-code width returned by the RAM.
- COL_BITS, 6, log2 of map columns (64).
- TILE_W, 10, pixels per tile horizontally (64 x 10 = 640).
- TILE_H, 15, lines per tile vertically (32 x 15 = 480).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel strobe; one pixel per clk where pix_en=1; minimum 1 idle clk between strobes is NOT required
- de_in  in  1  display enable from timing generator
- hs_in  in  1  hsync (polarity passed through)
- vs_in  in  1  vsync, active-low; starts a new frame
- addr  out  ADDR_WIDTH  tile-map address {trow, tcol}
- rdata  in  DATA_WIDTH  tile code, valid 1 clk after addr
- rgb  out  8  RGB332 pixel
- hs_out, vs_out, de_out  out  1 each  delayed syncs and enable

Behaviour:
- Reset: all counters 0; addr=0; rgb=0; de_out=0; hs_out=1; vs_out=1; pipeline registers cleared. Async assert, sync deassert handled upstream.
- Counters, all updated only when pix_en=1:
  - px 0..TILE_W-1, tcol 0..63, py 0..TILE_H-1, trow 0..31.
  - de_in=1: px++. When px=TILE_W-1, px wraps to 0 and tcol++ (tcol wraps 63 -> 0).
  - Falling edge of de_in (de_in=0 with the registered previous de=1): px=0, tcol=0, py++. When py=TILE_H-1, py wraps to 0 and trow++ (trow wraps 31 -> 0).
  - vs_in=0: px, tcol, py, trow all 0. This takes priority over the line-end update when both occur on the same strobe.
- No division or multiplication; counters only.
- Stage 1, on pix_en: addr <= {trow, tcol}; de/hs/vs captured into d1 registers.
  - addr is also held between strobes, so the RAM read completes 1 clk later regardless of pix_en spacing.
- Stage 2, on pix_en:
  - rgb <= palette[rdata] when de_d1=1, else 0.
  - de_out/hs_out/vs_out <= d1 values.
- Latency: exactly 2 pix_en strobes from de_in/hs_in/vs_in to the matching outputs.
- pix_en every clk is legal: rdata for stage 1's address arrives exactly at the next strobe.
- Default palette: code 0=8'h00, 1=8'h1C, 2=8'hE0, 3=8'hFF.
- Blanking: addr keeps advancing only while de_in=1; during blanking rgb is forced 0 whatever rdata returns.
- Reset mid-frame: everything returns to reset values; rendering resumes correctly after the next vs_in low.

Optional Feature:
- Macro BG_PALETTE_WR_EN.
- Defined: adds ports pal_we (in, 1), pal_idx (in, 2) and pal_data (in, 8).
  - The palette is 4 registers, reset to the default values.
  - A write takes effect on the clk edge where pal_we=1, and is visible to the next stage-2 lookup.
  - A write on the same clk as a lookup of the same index yields the old value.
- Undefined: the palette is a constant lookup, the ports are absent, and no palette registers exist.

Decomposition:
- Shared package bg_pkg holds:
  - RGB332 typedef
  - default palette constants PAL_DEF0..3
  - TILE_W/TILE_H/COL_BITS defaults
  - the sync-delay depth (2)
- One natural sub-module: bg_tile_counter, holding the px/tcol/py/trow counters with line-end and frame-reset logic.
- The palette and pipeline stay in the top module.

Test Plan:
- Reset: rst_n=0 mid-line -> addr=0, rgb=0, de_out=0, hs_out=vs_out=1 immediately, without waiting for a clk edge.
- First line, pix_en every clk, de_in=1 for 640 strobes:
  - addr steps 0 (x10), 1 (x10), ..., 63 (x10).
  - The RAM model returns code (addr mod 4); rgb follows palette[code] 2 strobes later.
  - After the line, tcol=0.
- Line/row wrap: drive 15 lines -> lines 0-14 use addr 0..63; line 15 starts at addr 64.
  - After 480 lines, a vs_in low pulse makes the next frame start at addr 0.
- pix_en every 4th clk: same address/rgb sequence as the first-line test; hs/vs/de outputs lag the inputs by exactly 2 strobes.
- Blanking: RAM returns 3 while de_in=0 -> rgb stays 8'h00 and addr is frozen.
- With BG_PALETTE_WR_EN: write pal_idx=1, pal_data=8'h03 -> subsequent code-1 pixels output 8'h03; reset restores 8'h1C.
